dcache_controller: RTL

Two-way set-associative, write-through, no-write-allocate data cache. It sits between the MEM stage and the SRAM controller. It takes the MEM-stage request (address, write data, rd_en/wr_en) and serves read hits in the same cycle. Read misses become two 32-bit SRAM transactions (line fill). Writes pass through to SRAM. The `ready` output freezes the pipeline while the cache is busy.

---
 rtl/dcache_pkg.sv | 43 ++++
 rtl/dcache_array.sv | 67 ++++++
 rtl/dcache_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address helpers for the 2-way data cache.
// Optional statistics (hit/miss counters) are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

  localparam logic [31:0] DATA_BASE  = 32'd1024;
  localparam int          INDEX_W    = 6;
  localparam int          ADDR_SIG_W = 19;
  localparam int          TAG_W      = ADDR_SIG_W - 3 - INDEX_W;
  localparam int          NUM_SETS   = 1 << INDEX_W;
  localparam int          NUM_WAYS   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_W0 = 3'd1,
    RD_W1 = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               word;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    logic [31:0]  off;
    addr_fields_t f;
    off     = addr - DATA_BASE;
    f.tag   = off[ADDR_SIG_W-1:INDEX_W+3];
    f.index = off[INDEX_W+2:3];
    f.word  = off[2];
    return f;
  endfunction

  // First byte of the 64-bit line holding addr, in absolute SRAM addressing.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - DATA_BASE;
    return DATA_BASE + {off[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data/LRU storage with two-way tag compare for the data cache.
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word,
  output logic               hit,
  output logic               hit_way,
  output logic [31:0]        hit_word,
  output logic               victim,
  input  logic               touch_en,
  input  logic               touch_way,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic [63:0]        fill_data,
  input  logic               upd_en,
  input  logic [31:0]        upd_data
);

  logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
  logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_r  [NUM_SETS][NUM_WAYS][2];
  logic [NUM_SETS-1:0] lru_r;
  logic [NUM_WAYS-1:0] way_hit_s;

  // Tag compare across both ways of the addressed set.
  always_comb begin
    way_hit_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_hit_s[w] = valid_r[index][w] && (tag_r[index][w] == tag);
    end
    hit      = |way_hit_s;
    hit_way  = way_hit_s[1];
    hit_word = data_r[index][hit_way][word];
    victim   = lru_r[index];
  end

  // Valid and LRU state; LRU always points at the way not used most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= '0;
      end
      lru_r <= '0;
    end else if (fill_en) begin
      valid_r[index][fill_way] <= 1'b1;
      lru_r[index]             <= ~fill_way;
    end else if (touch_en) begin
      lru_r[index] <= ~touch_way;
    end
  end

  // Tag and data arrays keep their contents through reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_r[index][fill_way]     <= tag;
      data_r[index][fill_way][0] <= fill_data[31:0];
      data_r[index][fill_way][1] <= fill_data[63:32];
    end else if (upd_en) begin
      data_r[index][hit_way][word] <= upd_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// 2-way write-through, no-write-allocate data cache between MEM stage and SRAM controller.
// Defining DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t       state_r, state_s;
  logic [31:0]  req_addr_r, req_wdata_r, word0_r, rdata_r;
  logic [31:0]  look_addr_s, hit_word_s;
  addr_fields_t fields_s;
  logic         hit_s, hit_way_s, victim_s;
  logic         rd_hit_s, upd_en_s, touch_en_s, fill_en_s;

  // While a transaction is in flight the lookup follows the latched request.
  assign look_addr_s = (state_r == IDLE) ? address : req_addr_r;
  assign fields_s    = split_addr(look_addr_s);
  assign rd_hit_s    = (state_r == IDLE) && rd_en && !wr_en && hit_s;
  assign upd_en_s    = (state_r == WRITE) && sram_ready && hit_s;
  assign touch_en_s  = rd_hit_s || upd_en_s;
  assign fill_en_s   = (state_r == RD_W1) && sram_ready;

  dcache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (fields_s.index),
    .tag       (fields_s.tag),
    .word      (fields_s.word),
    .hit       (hit_s),
    .hit_way   (hit_way_s),
    .hit_word  (hit_word_s),
    .victim    (victim_s),
    .touch_en  (touch_en_s),
    .touch_way (hit_way_s),
    .fill_en   (fill_en_s),
    .fill_way  (victim_s),
    .fill_data ({sram_rdata, word0_r}),
    .upd_en    (upd_en_s),
    .upd_data  (req_wdata_r)
  );

  // Next-state and output decode; SRAM enables depend on the state alone.
  always_comb begin
    state_s      = state_r;
    ready        = 1'b0;
    rdata        = 32'd0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = 32'd0;
    sram_wdata   = 32'd0;
    case (state_r)
      IDLE: begin
        if (wr_en) begin
          state_s = WRITE;
        end else if (rd_en) begin
          if (hit_s) begin
            ready = 1'b1;
            rdata = hit_word_s;
          end else begin
            state_s = RD_W0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_W0: begin
        sram_rd_en   = 1'b1;
        sram_address = line_addr(req_addr_r);
        state_s      = sram_ready ? RD_W1 : RD_W0;
      end
      RD_W1: begin
        sram_rd_en   = 1'b1;
        sram_address = line_addr(req_addr_r) + 32'd4;
        state_s      = sram_ready ? DONE : RD_W1;
      end
      WRITE: begin
        sram_wr_en   = 1'b1;
        sram_address = req_addr_r;
        sram_wdata   = req_wdata_r;
        state_s      = sram_ready ? DONE : WRITE;
      end
      DONE: begin
        ready   = 1'b1;
        rdata   = rdata_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, request latch and fill buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      req_addr_r  <= 32'd0;
      req_wdata_r <= 32'd0;
      word0_r     <= 32'd0;
      rdata_r     <= 32'd0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE) begin
        req_addr_r  <= address;
        req_wdata_r <= wdata;
      end
      if ((state_r == RD_W0) && sram_ready) begin
        word0_r <= sram_rdata;
      end
      if (fill_en_s) begin
        rdata_r <= fields_s.word ? sram_rdata : word0_r;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // Completed-read counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (rd_hit_s && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (fill_en_s && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
